// File: rtl/adder_seq.sv
// Request sequencer in front of the multi-cycle SIMD adder: queues add/sub requests,
// issues them one at a time with stable operands, and returns tagged results.
module adder_seq #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_v,
    output logic             req_rdy,
    input  logic [0:63]      req_op1,
    input  logic [0:63]      req_op2,
    input  logic [1:0]       req_ww,
    input  logic             req_sub,
    input  logic [0:TAG_W-1] req_tag,
    output logic [0:63]      add_op1,
    output logic [0:63]      add_in2,
    output logic [1:0]       add_ww,
    output logic             add_sub,
    output logic             add_in_v,
    input  logic [0:63]      add_out,
    input  logic             add_out_v,
    input  logic             add_ready,
    output logic             rsp_v,
    input  logic             rsp_rdy,
    output logic [0:63]      rsp_data,
    output logic [0:TAG_W-1] rsp_tag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [0:63]      op1;
        logic [0:63]      op2;
        logic [1:0]       ww;
        logic             sub;
        logic [0:TAG_W-1] tag;
    } entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    state_t           state_q, state_d;

    logic             rsp_v_q, rsp_v_d;
    logic [0:63]      rsp_data_q, rsp_data_d;
    logic [0:TAG_W-1] rsp_tag_q, rsp_tag_d;

    logic   push;
    logic   pop;
    logic   slot_free;
    logic   issue_ok;
    logic   capture;
    entry_t head;

    assign head      = mem_q[rd_ptr_q];
    assign req_rdy   = (count_q != CNT_FULL);
    assign push      = req_v && req_rdy;
    assign slot_free = !rsp_v_q || rsp_rdy;
    assign issue_ok  = (count_q != '0) && add_ready && slot_free;
    assign pop       = capture;

    // The head entry stays in the FIFO until its result is captured, so operands are stable.
    assign add_op1 = head.op1;
    assign add_in2 = head.op2;
    assign add_ww  = head.ww;
    assign add_sub = head.sub;

    assign rsp_v    = rsp_v_q;
    assign rsp_data = rsp_data_q;
    assign rsp_tag  = rsp_tag_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (issue_ok && !add_out_v) state_d = BUSY;
            BUSY: if (add_out_v) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset forces add_in_v low immediately so the adder never sees a stale request.
    always_comb begin
        add_in_v = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                add_in_v = issue_ok;
                capture  = issue_ok && add_out_v;
            end
            BUSY: begin
                add_in_v = 1'b1;
                capture  = add_out_v;
            end
            default: begin
                add_in_v = 1'b0;
                capture  = 1'b0;
            end
        endcase
        if (!reset) begin
            add_in_v = 1'b0;
            capture  = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{op1: req_op1, op2: req_op2, ww: req_ww,
                                 sub: req_sub, tag: req_tag};
        end
    end

    // A capture refills the slot even when the old response drains in the same cycle.
    always_comb begin
        rsp_v_d    = rsp_v_q;
        rsp_data_d = rsp_data_q;
        rsp_tag_d  = rsp_tag_q;
        if (capture) begin
            rsp_v_d    = 1'b1;
            rsp_data_d = add_out;
            rsp_tag_d  = head.tag;
        end else if (rsp_v_q && rsp_rdy) begin
            rsp_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_v_q    <= 1'b0;
            rsp_data_q <= '0;
            rsp_tag_q  <= '0;
        end else begin
            rsp_v_q    <= rsp_v_d;
            rsp_data_q <= rsp_data_d;
            rsp_tag_q  <= rsp_tag_d;
        end
    end

endmodule
